byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Upstream feeder for the 1-bit shift FIFO stage.
- Accepts DATA_W-bit words over a valid/ready handshake and buffers them in a DEPTH-entry circular word queue.
- Shifts each word out one bit per clock on a 1-bit serial line that drives the shift FIFO's `in` input.
- Continuous streaming with no idle gap between buffered words; the downstream stage can pause the stream with ser_ready.

Parameters:
- DATA_W, 8: word width, bits shifted per word.
- DEPTH, 4: word queue entries, power of 2, ≥2.
- MSB_FIRST, 1: 1 = bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  queue can accept a word.
- in_data  input  DATA_W  word to enqueue.
- ser_ready  input  1  downstream accepts a bit this cycle; 0 = hold.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a data bit.
- ser_last  output  1  ser_out is the final bit of a word.
- busy  output  1  FSM in SHIFT or queue non-empty.
- count  output  $clog2(DEPTH)+1  words held in queue (excludes word in shifter).

Behaviour:
- Reset (rst_n low, async): queue pointers, count, bit counter and shift register = 0; FSM = IDLE. Outputs: in_ready=1, ser_out=0, ser_valid=0, ser_last=0, busy=0, count=0.
  - Reset mid-word discards the word in flight and all queued words.
  - The first posedge after deassertion behaves as a normal IDLE cycle.
- Push:
  - Push = in_valid && in_ready.
  - in_ready = (count != DEPTH). It depends only on full, not on a same-cycle pop, so a full queue never accepts even if popping.
  - Write pointer wraps DEPTH-1 -> 0.
  - in_valid while full: word ignored; upstream must hold it.
- FSM IDLE:
  - ser_valid=0, ser_out=0.
  - If count>0 at a posedge: pop head into the shift register, bit counter = DATA_W-1, go to SHIFT.
  - Read pointer wraps.
- FSM SHIFT:
  - ser_valid=1; ser_out = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - Advance = ser_valid && ser_ready. On advance, shift one position (zero fill) and decrement the bit counter.
  - ser_last=1 when bit counter==0 in SHIFT.
  - On advance with ser_last=1:
    - If count>0: pop the next word straight into the shifter and stay in SHIFT (no bubble).
    - Else: go to IDLE.
  - ser_ready=0: shifter, counter, outputs and FSM state all hold; the queue still accepts pushes.
- Latency: word pushed at edge t into an empty queue with FSM IDLE:
  - count=1 after t.
  - Popped at edge t+1; first bit valid in cycle after t+1.
  - With ser_ready held 1, exactly DATA_W valid cycles follow.
- Simultaneous push and pop in the same cycle: count unchanged; both pointers advance.
- count and pointers never over- or underflow; a pop occurs only when count>0.
- busy = (state==SHIFT) || (count!=0).

Test Plan:
- Reset, then push 0xA5 with ser_ready=1 -> ser_valid high 8 cycles starting 2 cycles after push; ser_out = 1,0,1,0,0,1,0,1; ser_last on the 8th cycle; then IDLE with ser_out=0.
- Push 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles -> 32 contiguous valid bits with no gap, words in order; count peaks at 3; ser_last pulses every 8th bit.
- Fill queue with ser_ready=0 (5 words: 1 in shifter + 4 queued) -> in_ready=0, count=4; a 6th in_valid is not accepted. Raise ser_ready -> all 5 words emerge intact, in_ready returns 1 after the first pop.
- Toggle ser_ready 1,0,0,1,... during word 0xC3 -> ser_out holds during low cycles; full bit sequence 1,1,0,0,0,0,1,1 preserved.
- MSB_FIRST=0, push 0x01 -> first bit 1, then seven 0s.
- Assert rst_n=0 mid-word, 4th bit of 0xF0, with 2 words queued -> ser_valid, count, busy go 0 immediately (async); after release no stale bits are emitted.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: buffers DATA_W-bit words in a DEPTH-entry circular queue
// and streams them out one bit per clock behind a valid/ready serial handshake.
module byte_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     ser_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     ser_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bit_cnt;
    logic              push, pop, adv;

    assign push      = in_valid && in_ready;
    assign adv       = ser_valid && ser_ready;
    // A pop either starts a word from IDLE or chains the next word behind the last bit.
    assign pop       = count != '0 && (state == IDLE || (adv && ser_last));
    assign in_ready  = count != CW'(DEPTH);
    assign ser_valid = state == SHIFT;
    assign ser_last  = ser_valid && bit_cnt == '0;
    assign ser_out   = ser_valid && (MSB_FIRST ? sreg[DATA_W-1] : sreg[0]);
    assign busy      = ser_valid || count != '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                sreg    <= mem[rd_ptr];
                bit_cnt <= BW'(DATA_W - 1);
                state   <= SHIFT;
            end else if (adv) begin
                sreg    <= MSB_FIRST ? sreg << 1 : sreg >> 1;
                bit_cnt <= bit_cnt - 1'b1;
                if (ser_last) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: scoreboard bench for byte_serializer, MSB-first main
// instance plus an LSB-first instance for bit-order checks.
module tb_byte_serializer;
    logic       clk, rst_n;
    logic       in_valid, in_ready, ser_ready, ser_out, ser_valid, ser_last, busy;
    logic [7:0] in_data;
    logic [2:0] count;
    logic       l_valid, l_in_ready, l_ready, l_out, l_sv, l_last, l_busy;
    logic [7:0] l_data;
    logic [2:0] l_cnt;

    byte_serializer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ser_ready(ser_ready), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy), .count(count)
    );

    byte_serializer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(l_valid), .in_ready(l_in_ready),
        .in_data(l_data), .ser_ready(l_ready), .ser_out(l_out),
        .ser_valid(l_sv), .ser_last(l_last), .busy(l_busy), .count(l_cnt)
    );

    int         n_chk = 0, n_pass = 0;
    logic [1:0] sb [$];
    logic       gap_en = 0, started = 0;
    int         gap_cnt = 0;
    logic [2:0] max_cnt = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Monitor: every accepted serial bit is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n) begin
            if (count > max_cnt) max_cnt = count;
            if (ser_valid) started = 1;
            else if (gap_en && started && sb.size() != 0) gap_cnt++;
            if (ser_valid && ser_ready) begin
                if (sb.size() == 0) check("stray_bit", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("ser_out", ser_out, e[1]);
                    check("ser_last", ser_last, e[0]);
                end
            end
        end
    end

    task automatic push_word(logic [7:0] w);
        int n = 0;
        in_valid = 1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        for (int i = 0; i < 8; i++) sb.push_back({w[7-i], i == 7});
    endtask

    task automatic drain(int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [4];
        logic hold_ref, prev_out;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 0; in_valid = 0; in_data = 0; ser_ready = 1;
        l_valid = 0; l_data = 0; l_ready = 1;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_out", ser_out, 0);
        check("rst_ser_last", ser_last, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // single word latency and bit pattern
        push_word(8'hA5);
        check("lat_count", count, 1);
        check("lat_valid0", ser_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid1", ser_valid, 1);
        check("lat_count0", count, 0);
        drain(40);
        check("idle_valid", ser_valid, 0);
        check("idle_out", ser_out, 0);
        check("idle_busy", busy, 0);

        // back-to-back words stream without bubbles
        gap_cnt = 0; started = 0; max_cnt = 0; gap_en = 1;
        push_word(8'hA5);
        push_word(8'h3C);
        push_word(8'hFF);
        push_word(8'h00);
        drain(80);
        gap_en = 0;
        check("stream_gaps", gap_cnt, 0);
        check("count_peak", max_cnt, 3);

        // fill with downstream stalled
        ser_ready = 0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        in_valid = 1; in_data = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        check("full_reject_cnt", count, 4);
        check("full_reject_rdy", in_ready, 0);
        in_valid = 0;
        ser_ready = 1;
        repeat (7) @(posedge clk);
        #1;
        check("still_full", in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_pop", in_ready, 1);
        drain(100);

        // stall pattern mid-word
        push_word(8'hC3);
        hold_ref = 0; prev_out = 0;
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            ser_ready = pat[i % 4];
            @(negedge clk);
            if (hold_ref) check("hold_out", ser_out, prev_out);
            hold_ref = ser_valid && !ser_ready;
            prev_out = ser_out;
            @(posedge clk);
            #1;
        end
        ser_ready = 1;
        drain(40);

        // LSB-first instance
        l_valid = 1; l_data = 8'h01;
        @(posedge clk);
        #1;
        l_valid = 0;
        check("lsb_count", l_cnt, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            check("lsb_valid", l_sv, 1);
            check("lsb_out", l_out, i == 0);
            check("lsb_last", l_last, i == 7);
            @(posedge clk);
            #1;
        end
        check("lsb_idle", l_sv, 0);

        // async reset mid-word with queued words
        push_word(8'hF0);
        push_word(8'h5A);
        push_word(8'h69);
        check("pre_rst_count", count, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", ser_valid, 1);
        rst_n = 0;
        #1;
        check("arst_valid", ser_valid, 0);
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_valid", ser_valid, 0);
        check("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
